cordic_phase_prep: RTL and testbench

//  Upstream feeder of the pipelined CORDIC rotation chain (sin/cos, rotation mode).

---
 rtl/cordic_phase_prep_if.sv | 24 ++
 rtl/cordic_phase_prep.sv | 76 +++++++
 tb/tb_cordic_phase_prep.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cordic_phase_prep_if.sv
// rtl/cordic_phase_prep_if.sv - phase-in / CORDIC-seed-out bundle for cordic_phase_prep
interface cordic_phase_prep_if #(
  parameter int W           = 16,
  parameter int PHASE_WIDTH = 16
);
  logic                   en;
  logic                   valid_in;
  logic [PHASE_WIDTH-1:0] phase_in;
  logic signed [W-1:0]    x_0;
  logic signed [W-1:0]    y_0;
  logic signed [W-1:0]    z_0;
  logic [1:0]             quad_out;
  logic                   valid_out;

  modport master (
    output en, valid_in, phase_in,
    input  x_0, y_0, z_0, quad_out, valid_out
  );

  modport slave (
    input  en, valid_in, phase_in,
    output x_0, y_0, z_0, quad_out, valid_out
  );
endinterface

// File: rtl/cordic_phase_prep.sv
// rtl/cordic_phase_prep.sv - folds a full-circle phase into a CORDIC seed and delays the quadrant tag
module cordic_phase_prep #(
  parameter int SYM_WIDTH   = 1,
  parameter int INT_WIDTH   = 1,
  parameter int DEC_WIDTH   = 14,
  parameter int PHASE_WIDTH = 16,
  parameter int ITER_NUM    = 14,
  parameter int K_INIT      = 9949,
  parameter int PI_HALF     = 25736
) (
  input logic                clk_i,
  input logic                rst_i,
  cordic_phase_prep_if.slave bus
);
  localparam int W      = SYM_WIDTH + INT_WIDTH + DEC_WIDTH;
  localparam int R_W    = PHASE_WIDTH - 2;
  localparam int PROD_W = R_W + W;
  localparam int ROUND  = 1 << (PHASE_WIDTH - 3);

  if (PHASE_WIDTH < 4 || ITER_NUM < 1) begin : g_param_check
    $error("cordic_phase_prep: PHASE_WIDTH must be >= 4 and ITER_NUM >= 1");
  end

  logic [1:0]     q1_q;
  logic [R_W-1:0] r1_q;
  logic           v1_q;

  logic [W-1:0]   x_q;
  logic [W-1:0]   y_q;
  logic [W-1:0]   z_q;
  logic [1:0]     q2_q;
  logic           v2_q;

  logic [2:0]     tag_q [ITER_NUM];

  logic [PROD_W-1:0] prod_d;
  logic [W-1:0]      z_d;

  // Quarter-circle residual scaled to radians, rounded half up.
  always_comb begin
    prod_d = PROD_W'(r1_q) * PROD_W'(PI_HALF);
    z_d    = W'((prod_d + PROD_W'(ROUND)) >> R_W);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q1_q <= '0;
      r1_q <= '0;
      v1_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
      z_q  <= '0;
      q2_q <= '0;
      v2_q <= 1'b0;
      for (int i = 0; i < ITER_NUM; i++) tag_q[i] <= '0;
    end else if (bus.en) begin
      q1_q <= bus.phase_in[PHASE_WIDTH-1 -: 2];
      r1_q <= bus.phase_in[R_W-1:0];
      v1_q <= bus.valid_in;
      x_q  <= W'(K_INIT);
      y_q  <= '0;
      z_q  <= z_d;
      q2_q <= q1_q;
      v2_q <= v1_q;
      // Tag line depth matches the iteration chain so the tag meets x_N/y_N.
      tag_q[0] <= {v2_q, q2_q};
      for (int i = 1; i < ITER_NUM; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign bus.x_0       = x_q;
  assign bus.y_0       = y_q;
  assign bus.z_0       = z_q;
  assign bus.quad_out  = tag_q[ITER_NUM-1][1:0];
  assign bus.valid_out = tag_q[ITER_NUM-1][2];
endmodule

// File: tb/tb_cordic_phase_prep.sv
// tb/tb_cordic_phase_prep.sv - scoreboard bench for cordic_phase_prep
module tb_cordic_phase_prep;
  localparam int          TAG_LAT = 16;
  localparam logic [15:0] K_EXP   = 16'd9949;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cordic_phase_prep_if #(.W(16), .PHASE_WIDTH(16)) bus ();

  cordic_phase_prep dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  logic [15:0] zq [$];
  logic [2:0]  tq [$];

  logic [15:0] last_x, last_y, last_z;
  logic [1:0]  last_q;
  logic        last_v;

  function automatic logic [15:0] model_z(input logic [15:0] ph);
    logic [31:0] r;
    r = {18'd0, ph[13:0]};
    return 16'((r * 32'd25736 + 32'd8192) >> 14);
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [15:0] ex, ey, ez, input logic [1:0] eq, input logic ev);
    chk("x_0", bus.x_0, ex);
    chk("y_0", bus.y_0, ey);
    chk("z_0", bus.z_0, ez);
    chk("quad_out", {14'd0, bus.quad_out}, {14'd0, eq});
    chk("valid_out", {15'd0, bus.valid_out}, {15'd0, ev});
    last_x = ex; last_y = ey; last_z = ez; last_q = eq; last_v = ev;
  endtask

  task automatic step(input logic rst_v, input logic en_v, input logic vin, input logic [15:0] ph);
    logic [15:0] ez, ex;
    logic [2:0]  et;
    rst          = rst_v;
    bus.en       = en_v;
    bus.valid_in = vin;
    bus.phase_in = ph;
    if (!rst_v && en_v) begin
      zq.push_back(model_z(ph));
      tq.push_back({vin, ph[15:14]});
    end
    @(posedge clk);
    #1;
    if (rst_v) begin
      zq.delete();
      tq.delete();
      check_all(16'd0, 16'd0, 16'd0, 2'd0, 1'b0);
    end else if (en_v) begin
      // Right after reset, stage 2 is loaded from a cleared stage 1.
      if (zq.size() == 2) ez = zq.pop_front();
      else                ez = 16'd0;
      ex = K_EXP;
      if (tq.size() == TAG_LAT) et = tq.pop_front();
      else                      et = 3'b000;
      check_all(ex, 16'd0, ez, et[1:0], et[2]);
    end else begin
      check_all(last_x, last_y, last_z, last_q, last_v);
    end
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 16'h0000);
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b1;
    bus.valid_in = 1'b0;
    bus.phase_in = '0;

    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 16'h0000);

    step(1'b0, 1'b1, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'h2000);
    step(1'b0, 1'b1, 1'b1, 16'h4000);
    step(1'b0, 1'b1, 1'b1, 16'hE000);

    step(1'b0, 1'b1, 1'b1, 16'h3FFF);
    step(1'b0, 1'b1, 1'b1, 16'hFFFF);

    step(1'b0, 1'b1, 1'b1, 16'h1234);
    step(1'b0, 1'b1, 1'b0, 16'h9ABC);
    step(1'b0, 1'b1, 1'b1, 16'h5555);
    step(1'b0, 1'b1, 1'b1, 16'hC001);
    step(1'b0, 1'b1, 1'b0, 16'h7FFF);

    step(1'b0, 1'b1, 1'b1, 16'h8000);
    step(1'b0, 1'b1, 1'b1, 16'hA5A5);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 16'hDEAD);
    step(1'b0, 1'b1, 1'b1, 16'h6000);
    step(1'b0, 1'b1, 1'b1, 16'hBFFF);

    drain(TAG_LAT + 2);

    step(1'b0, 1'b1, 1'b1, 16'h1111);
    step(1'b0, 1'b1, 1'b1, 16'h4444);
    step(1'b0, 1'b1, 1'b1, 16'h8888);
    step(1'b0, 1'b1, 1'b1, 16'hCCCC);
    step(1'b0, 1'b1, 1'b1, 16'hF0F0);
    step(1'b1, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b1, 16'hE123);
    drain(TAG_LAT + 2);

    for (int i = 0; i < 40; i++)
      step(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 16'($urandom));
    drain(TAG_LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
